cache_refill_ctrl: RTL
======================

Name: cache_refill_ctrl

Overview:
- Miss/refill engine directly downstream of the 2-way set-associative dCache/iCache.
- On a cache miss it accepts the block address and the LRU victim way, then fetches the whole block from main memory one 32-bit word at a time.
- It returns the assembled block to the cache for installation into the chosen way, and holds the pipeline stalled while busy.
- Instanced once per cache: WORDS_PER_BLOCK=2 for dCache, 4 for iCache.

Parameters:
- WORDS_PER_BLOCK, 4, words per cache block; must be a power of 2, ≥2.
- OFFSET_BITS, log2(WORDS_PER_BLOCK)+2, byte-offset width of a block address.

Ports:
- CLK  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- miss_req  in  1  cache reports a miss; level, sampled only when miss_ready=1.
- miss_addr  in  32  faulting byte address; any alignment.
- miss_way  in  1  victim way chosen by the cache's LRU bit.
- miss_ready  out  1  engine idle; a miss can be accepted this cycle.
- stall  out  1  pipeline hold request.
- mem_req  out  1  word read request to main memory.
- mem_addr  out  32  word-aligned read address.
- mem_rvalid  in  1  memory returns mem_rdata for the current mem_addr.
- mem_rdata  in  32  read data.
- refill_valid  out  1  one-cycle pulse: block complete.
- refill_addr  out  32  block-aligned address of the refilled block.
- refill_way  out  1  latched miss_way.
- refill_data  out  32*WORDS_PER_BLOCK  block; word i at bits [32i+31:32i], address refill_addr+4i.

Behaviour:
- FSM states IDLE, FETCH, DONE; encoding is free.
- Reset (async, any state, including mid-fetch):
  - state→IDLE, word counter→0.
  - Internal base address, way, and data registers→0.
  - All outputs 0 except miss_ready=1.
  - A partially fetched block is discarded and no refill_valid is produced.
- IDLE:
  - miss_ready=1, mem_req=0, stall=miss_req.
  - On miss_req=1 at a clock edge, latch:
    - base = miss_addr with bits [OFFSET_BITS-1:0] cleared;
    - way = miss_way;
    - cnt = 0.
  - Then go to FETCH. miss_addr and miss_way are don't-care after acceptance.
- FETCH:
  - miss_ready=0, stall=1, mem_req=1.
  - mem_addr = base + 4*cnt, held stable until mem_rvalid=1.
  - On an edge with mem_rvalid=1:
    - data word[cnt] ← mem_rdata;
    - if cnt==WORDS_PER_BLOCK-1, go to DONE; otherwise cnt+1 and stay in FETCH.
  - mem_rvalid may arrive in the same cycle mem_req rises (zero-wait memory) or any number of cycles later; there is no timeout.
  - The counter never exceeds WORDS_PER_BLOCK-1.
- DONE (exactly one cycle):
  - refill_valid=1, stall=1, mem_req=0, miss_ready=0.
  - Next state is IDLE unconditionally.
  - A miss_req asserted during DONE is not accepted until the following IDLE cycle.
- Output holding:
  - refill_addr, refill_way, and refill_data reflect the latched registers continuously.
  - refill_data is stable from DONE until the next miss is accepted, so the cache may also sample it a cycle late.
  - refill_data shows partial contents during FETCH; the cache uses it only under refill_valid.
- Ignored inputs: mem_rvalid outside FETCH and miss_req outside IDLE. The held miss_req is simply re-sampled in IDLE. Because the cache holds miss_req until refill install completes, it must deassert it the cycle after refill_valid to avoid a duplicate fetch.
- Arithmetic: the mem_addr add is 32-bit modulo. A block at 0xFFFFFFF0 fetches 0xFFFFFFF0..0xFFFFFFFC with no carry into a new block, because base is aligned.
- Latency with zero-wait memory is WORDS_PER_BLOCK+1 cycles from the accepting edge to the refill_valid cycle. Each memory wait cycle adds 1.

Test Plan:
- Reset, then idle → miss_ready=1, stall=0, mem_req=0, refill_valid=0, refill_data=0.
- WPB=4, miss_addr=0x0000_1234, way=1, zero-wait memory returning 0xA0,0xA1,0xA2,0xA3:
  - mem_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles;
  - refill_valid pulses on the 5th cycle after acceptance with refill_addr=0x1230, refill_way=1, refill_data=0x000000A3_000000A2_000000A1_000000A0.
- WPB=2, miss_addr=0x0000_2004, memory with 3 wait cycles per word:
  - mem_addr holds 0x2000 for 4 cycles, then 0x2004 for 4 cycles;
  - refill_valid arrives 9 cycles after acceptance;
  - stall=1 throughout.
- Spurious mem_rvalid=1 with mem_rdata=0xDEAD in IDLE and DONE → no data register change; the next refill data is correct.
- reset pulsed mid-FETCH after word 1 → immediate IDLE, mem_req=0, no refill_valid; a new miss to 0x4000 then completes normally with correct data.
- miss_req held high through DONE → exactly one refill; IDLE is re-entered with miss_ready=1, and a second fetch of the same block starts only if miss_req is still high in IDLE.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Miss/refill engine for a 2-way set-associative cache: fetches one block word by word
// from main memory and hands the assembled block back for installation into the victim way.
module cache_refill_ctrl #(
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned OFFSET_BITS     = $clog2(WORDS_PER_BLOCK) + 2
) (
   input  logic                          CLK,
   input  logic                          reset,
   input  logic                          miss_req,
   input  logic [31:0]                   miss_addr,
   input  logic                          miss_way,
   output logic                          miss_ready,
   output logic                          stall,
   output logic                          mem_req,
   output logic [31:0]                   mem_addr,
   input  logic                          mem_rvalid,
   input  logic [31:0]                   mem_rdata,
   output logic                          refill_valid,
   output logic [31:0]                   refill_addr,
   output logic                          refill_way,
   output logic [32*WORDS_PER_BLOCK-1:0] refill_data
);

   localparam int unsigned CNT_W  = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned DATA_W = 32 * WORDS_PER_BLOCK;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [31:0] BLOCK_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [31:0]         base;
   logic                way;
   logic [DATA_W-1:0]   data;

   // mem_addr is kept as a running copy of base + 4*cnt so it leaves the block registered
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         base         <= '0;
         way          <= 1'b0;
         data         <= '0;
         miss_ready   <= 1'b1;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         refill_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               refill_valid <= 1'b0;
               if (miss_req) begin
                  base       <= miss_addr & BLOCK_MASK;
                  mem_addr   <= miss_addr & BLOCK_MASK;
                  way        <= miss_way;
                  cnt        <= '0;
                  miss_ready <= 1'b0;
                  mem_req    <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               if (mem_rvalid) begin
                  data[{cnt, 5'd0} +: 32] <= mem_rdata;
                  if (cnt == LAST_WORD) begin
                     mem_req      <= 1'b0;
                     refill_valid <= 1'b1;
                     state        <= DONE;
                  end else begin
                     cnt      <= cnt + CNT_W'(1);
                     mem_addr <= mem_addr + 32'd4;
                  end
               end
            end
            DONE: begin
               refill_valid <= 1'b0;
               miss_ready   <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               mem_req      <= 1'b0;
               refill_valid <= 1'b0;
               miss_ready   <= 1'b1;
               state        <= IDLE;
            end
         endcase
      end
   end

   // Idle only stalls when the cache is reporting a miss; otherwise the engine is busy.
   assign stall       = !miss_ready || miss_req;
   assign refill_addr = base;
   assign refill_way  = way;
   assign refill_data = data;

endmodule
